// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, sequencer states and the
// instruction-memory geometry used by both the sequencer and the memory.
package cpu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } seq_state_t;

    // Word-indexed instruction memory: first fetch address, fall-through
    // increment and number of valid words.
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC   = '0;
    localparam logic [XLEN-1:0] DEFAULT_PC_STEP    = XLEN'(1);
    localparam logic [XLEN-1:0] DEFAULT_IMEM_DEPTH = XLEN'(1024);

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC select (fall-through or branch redirect) plus fetch range check.
// Purely combinational; the sequencer decides whether the result is used.
module pc_next_logic
    import cpu_pkg::*;
#(
    parameter int              XLEN       = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] PC_STEP    = DEFAULT_PC_STEP,
    parameter logic [XLEN-1:0] IMEM_DEPTH = DEFAULT_IMEM_DEPTH
) (
    input  logic [XLEN-1:0] pc,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic [XLEN-1:0] next_pc,
    output logic            out_of_range
);

    // One extra bit so a fall-through past the top of the address space is
    // caught as a fault instead of silently wrapping to a valid low address.
    logic [XLEN:0] fall_through;

    assign fall_through = {1'b0, pc} + {1'b0, PC_STEP};

    // Pick the successor address, then flag it if it leaves instruction memory.
    always_comb begin
        next_pc      = fall_through[XLEN-1:0];
        out_of_range = fall_through[XLEN];
        if (br_taken) begin
            next_pc      = br_target;
            out_of_range = 1'b0;
        end
        if (next_pc >= IMEM_DEPTH) begin
            out_of_range = 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/sequencing controller for the single-cycle core: starts and stops
// execution, steps or redirects the PC once per clock, holds it on stall,
// counts retirements, enforces an optional step limit and traps bad fetches.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int              XLEN       = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] PC_STEP    = DEFAULT_PC_STEP,
    parameter logic [XLEN-1:0] IMEM_DEPTH = DEFAULT_IMEM_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            halt_req,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] step_limit,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            busy,
    output logic            done,
    output logic            fault,
    output logic [XLEN-1:0] retired
);

    seq_state_t      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] retired_q, retired_d;
    logic [XLEN-1:0] limit_q, limit_d;
    logic            done_q, done_d;

    logic [XLEN-1:0] next_pc;
    logic            out_of_range;
    logic [XLEN:0]   retired_plus1;
    logic [XLEN-1:0] retired_sat;
    logic            limit_hit;

    pc_next_logic #(
        .XLEN       (XLEN),
        .PC_STEP    (PC_STEP),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_pc_next (
        .pc           (pc_q),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .next_pc      (next_pc),
        .out_of_range (out_of_range)
    );

    // Retirement count after this instruction, and whether it meets the limit.
    assign retired_plus1 = {1'b0, retired_q} + {{XLEN{1'b0}}, 1'b1};
    assign retired_sat   = retired_plus1[XLEN] ? retired_q : retired_plus1[XLEN-1:0];
    assign limit_hit     = (limit_q != '0) && (retired_plus1 == {1'b0, limit_q});

    // Next-state, next-PC and counter update for the sequencing FSM.
    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path through
        // the case leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        limit_d   = limit_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE, HALTED, FAULT: begin
                if (start) begin
                    state_d   = RUN;
                    pc_d      = RESET_PC;
                    retired_d = '0;
                    limit_d   = step_limit;
                end
            end
            RUN: begin
                if (stall) begin
                    // Stalled instruction has not completed: nothing retires.
                    if (halt_req) begin
                        state_d = HALTED;
                        done_d  = 1'b1;
                    end
                end else begin
                    retired_d = retired_sat;
                    if (out_of_range) begin
                        // PC stays on the offending instruction for debug.
                        state_d = FAULT;
                    end else begin
                        pc_d = next_pc;
                        if (halt_req || limit_hit) begin
                            state_d = HALTED;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, PC, counter and pulse registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the values from before this edge, independent of statement order.
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            limit_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            limit_q   <= limit_d;
            done_q    <= done_d;
        end
    end

    // Outputs come straight from registers or a decode of the state register.
    assign pc       = pc_q;
    assign pc_valid = (state_q == RUN);
    assign busy     = (state_q == RUN);
    assign fault    = (state_q == FAULT);
    assign done     = done_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: clean stepping, step limit
// and restart, branch with stall, fetch faults, stall+halt and async reset.
module tb_pc_sequencer;
    import cpu_pkg::*;

    localparam int XL = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic          halt_req;
    logic          stall;
    logic          br_taken;
    logic [XL-1:0] br_target;
    logic [XL-1:0] step_limit;
    logic [XL-1:0] pc;
    logic          pc_valid;
    logic          busy;
    logic          done;
    logic          fault;
    logic [XL-1:0] retired;

    int n_checks;
    int n_fail;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .halt_req   (halt_req),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .step_limit (step_limit),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit after the last edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [XL-1:0] limit);
        start      = 1'b1;
        step_limit = limit;
        step(1);
        start      = 1'b0;
        step_limit = '0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        start      = 1'b0;
        halt_req   = 1'b0;
        stall      = 1'b0;
        br_taken   = 1'b0;
        br_target  = '0;
        step_limit = '0;

        // Reset values.
        #2;
        check("rst_pc", pc, 0);
        check("rst_valid", pc_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_retired", retired, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1);
        check("idle_pc", pc, 0);
        check("idle_busy", busy, 0);

        // Clean run, limit 0; a start while running must be ignored.
        do_start(0);
        check("t1_busy", busy, 1);
        check("t1_valid", pc_valid, 1);
        check("t1_retired0", retired, 0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t1_pc%0d", i), pc, i);
            start = (i == 4);
            step(1);
        end
        start = 1'b0;
        check("t1_pc_end", pc, 10);
        check("t1_retired", retired, 10);
        check("t1_busy_end", busy, 1);
        check("t1_done", done, 0);

        // Explicit halt: retires this instruction and stops at the resume point.
        halt_req = 1'b1;
        step(1);
        halt_req = 1'b0;
        check("hlt_done", done, 1);
        check("hlt_busy", busy, 0);
        check("hlt_pc", pc, 11);
        check("hlt_retired", retired, 11);

        // Step limit of 4, then restart.
        do_start(4);
        check("t2_pc0", pc, 0);
        check("t2_ret0", retired, 0);
        step(3);
        check("t2_done_early", done, 0);
        check("t2_ret3", retired, 3);
        step(1);
        check("t2_done", done, 1);
        check("t2_ret4", retired, 4);
        check("t2_pc4", pc, 4);
        check("t2_busy", busy, 0);
        step(1);
        check("t2_done_pulse", done, 0);
        check("t2_busy_after", busy, 0);
        check("t2_pc_hold", pc, 4);
        do_start(0);
        check("t2_restart_pc", pc, 0);
        check("t2_restart_ret", retired, 0);
        check("t2_restart_busy", busy, 1);

        // Branch at pc=3 to 20, then a stalled redirect that must be ignored.
        step(3);
        check("t3_pc3", pc, 3);
        br_taken  = 1'b1;
        br_target = 20;
        step(1);
        check("t3_pc20", pc, 20);
        check("t3_ret4", retired, 4);
        stall     = 1'b1;
        br_target = 30;
        step(1);
        check("t3_stall_pc", pc, 20);
        check("t3_stall_ret", retired, 4);
        check("t3_stall_valid", pc_valid, 1);
        stall    = 1'b0;
        br_taken = 1'b0;
        step(1);
        check("t3_pc21", pc, 21);
        check("t3_ret5", retired, 5);

        // Branch to IMEM_DEPTH from pc=5 faults and holds pc.
        br_taken  = 1'b1;
        br_target = 5;
        step(1);
        check("t4_pc5", pc, 5);
        br_target = 1024;
        step(1);
        br_taken = 1'b0;
        check("t4_fault", fault, 1);
        check("t4_pc", pc, 5);
        check("t4_done", done, 0);
        check("t4_busy", busy, 0);
        check("t4_valid", pc_valid, 0);
        step(1);
        check("t4_fault_hold", fault, 1);

        // Start clears the fault; fall-through from the last word faults.
        do_start(0);
        check("t4_clear", fault, 0);
        check("t4_restart_pc", pc, 0);
        br_taken  = 1'b1;
        br_target = 1023;
        step(1);
        br_taken = 1'b0;
        check("t4_pc_last", pc, 1023);
        check("t4_last_fault0", fault, 0);
        step(1);
        check("t4b_fault", fault, 1);
        check("t4b_pc", pc, 1023);
        check("t4b_done", done, 0);

        // Stall together with halt at pc=7.
        do_start(0);
        step(7);
        check("t5_pc7", pc, 7);
        check("t5_ret7", retired, 7);
        stall    = 1'b1;
        halt_req = 1'b1;
        step(1);
        stall    = 1'b0;
        halt_req = 1'b0;
        check("t5_pc", pc, 7);
        check("t5_ret", retired, 7);
        check("t5_done", done, 1);
        check("t5_busy", busy, 0);
        step(1);
        check("t5_done_pulse", done, 0);

        // Asynchronous reset between edges while running at pc=6.
        do_start(0);
        step(6);
        check("t6_pc6", pc, 6);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6_pc", pc, 0);
        check("t6_valid", pc_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_fault", fault, 0);
        check("t6_retired", retired, 0);
        check("t6_state", 32'(dut.state_q), 32'(IDLE));
        step(1);
        reset = 1'b0;
        step(1);
        check("t6_idle_busy", busy, 0);
        check("t6_idle_done", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/sequencing controller that drives the `pc` input of the single-cycle CPU core in place of a free-running testbench counter. It starts and stops execution, advances or redirects the program counter one instruction per clock, holds it on stall, counts retired instructions, enforces an optional step limit, and flags out-of-range fetches. It sits between the system/test harness and the CPU core, sharing the core's clock.

## Interface
- `XLEN`, 32: PC and counter width.
- `RESET_PC`, 0: first instruction address after `start`.
- `PC_STEP`, 1: fall-through increment; instruction memory is word-indexed.
- `IMEM_DEPTH`, 1024: valid fetch range is `0 .. IMEM_DEPTH-1`.

- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  begin (or restart) execution; honoured in IDLE, HALTED and FAULT only.
- `halt_req`  in  1  stop execution (see Operation).
- `stall`  in  1  current instruction does not complete this cycle; hold PC.
- `br_taken`  in  1  the current instruction redirects control flow.
- `br_target`  in  XLEN  redirect address, valid with `br_taken`.
- `step_limit`  in  XLEN  halt after this many retirements; 0 = unlimited; sampled on `start`.
- `pc`  out  XLEN  address of the instruction being executed.
- `pc_valid`  out  1  `pc` holds a live instruction this cycle.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse on entry to HALTED.
- `fault`  out  1  high while in FAULT.
- `retired`  out  XLEN  retired-instruction count since the last `start`.

## Operation
- States: IDLE, RUN, HALTED, FAULT.
- IDLE/HALTED/FAULT + `start` -> RUN: `pc`=RESET_PC, `retired`=0, step limit latched, `fault` cleared. `start` in RUN is ignored.
- RUN, each cycle, priority order:
  1. `stall`=1 and `halt_req`=1: -> HALTED, no retirement, `pc` held.
  2. `stall`=1: stay in RUN, `pc` and `retired` held.
  3. Otherwise the instruction retires (`retired`+1). Next = `br_taken` ? `br_target` : `pc`+PC_STEP, computed at XLEN width with no wrap.
  4. Next >= IMEM_DEPTH (including fall-through from the last word, or XLEN overflow): -> FAULT, `pc` held at the faulting instruction, `done` not pulsed. Fault takes priority over halt and limit.
  5. Else, if `halt_req`=1 or (latched limit != 0 and `retired`+1 == limit): `pc`<=next -> HALTED, `done` pulses. `pc` is the resume point.
  6. Else `pc`<=next, stay in RUN.
- `br_taken` is ignored while `stall`=1.
- `halt_req`, `stall` and `br_taken` are ignored outside RUN.
- `retired` saturates at all-ones.
- `reset` asserted in any state, including mid-RUN: immediate return to reset values; no `done` pulse.

## Timing
- All outputs are registered. No combinational input-to-output path.
- Reset values: state=IDLE, `pc`=RESET_PC, `pc_valid`=0, `busy`=0, `done`=0, `fault`=0, `retired`=0.
- `start` sampled at edge n -> `pc`=RESET_PC, `pc_valid`=1, `busy`=1 from edge n.
- Throughput is one retirement per non-stalled RUN cycle. Redirect takes effect at the next edge with no bubble.
- `pc_valid` = (state==RUN). It stays high during stall cycles, because the instruction is still live.
- `done` is high for exactly the one cycle after the transition edge into HALTED.
- Limit reached at edge m -> `retired`==limit and `done`=1 from edge m.

## Structure
- Shared package `cpu_pkg` holds:
  - `XLEN`.
  - `seq_state_t` enum {IDLE, RUN, HALTED, FAULT}.
  - Default `RESET_PC`, `PC_STEP` and `IMEM_DEPTH` constants, also used by the instruction memory.
- Sub-module `pc_next_logic`: combinational next-PC select plus range check. Outputs are next address and `out_of_range`. The FSM, PC register and counters live in `pc_sequencer`.

## Test plan
- Reset, then `start` with limit 0 and 10 clean cycles -> `pc` = 0,1,…,9 on successive cycles, `retired`=10, `busy`=1, `done`=0.
- `start` with `step_limit`=4 -> `done` pulses once with `retired`=4 and `pc`=4; `busy`=0 afterwards; a second `start` restarts at `pc`=0 with `retired`=0.
- At `pc`=3 apply `br_taken`=1, `br_target`=20; next cycle repeat with `stall`=1 -> `pc`=20, then held at 20, `retired` held, redirect ignored.
- `br_target`=IMEM_DEPTH at `pc`=5 -> FAULT, `fault`=1, `pc`=5, `done`=0; separately, fall-through from `pc`=IMEM_DEPTH-1 -> FAULT.
- Same cycle `stall`=1 and `halt_req`=1 at `pc`=7 with `retired`=7 -> HALTED, `pc`=7, `retired`=7, `done` pulses.
- Assert `reset` mid-RUN at `pc`=6 between clock edges -> all outputs at reset values immediately, before the next edge; state IDLE.
